ucie_ctl_adapter_data_transfer: RTL and testbench
=================================================

Name: ucie_ctl_adapter_data_transfer

Overview:
- Adapter (LP) side of the RDI data path: transmits flits into the PHY and captures flits the PHY returns.
- Buffers upstream flits in a DEPTH-entry FIFO and drives lp_valid/lp_irdy/lp_data, popping on pl_trdy.
- Registers pl_valid/pl_data toward the upstream consumer and keeps 16-bit tx/rx flit counters plus a stall watchdog.
- Enabled by the link FSM via i_enable.

Parameters:
- NBYTES, 32, flit width in bytes.
- DEPTH, 4, TX FIFO entries; must be a power of two, at least 2.
- STALL_LIMIT, 16, consecutive cycles of lp_valid without pl_trdy before the stall error sets; at least 1.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  link FSM enable.
- i_tx_valid  input  1  upstream flit valid.
- i_tx_data  input  [NBYTES-1:0][7:0]  upstream flit.
- o_tx_ready  output  1  FIFO can accept a flit.
- i_rdi_pl_trdy  input  1  PHY ready.
- i_rdi_pl_valid  input  1  PHY return-data valid.
- i_rdi_pl_data  input  [NBYTES-1:0][7:0]  PHY return data.
- o_rdi_lp_irdy  output  1  adapter has data.
- o_rdi_lp_valid  output  1  lp_data valid.
- o_rdi_lp_data  output  [NBYTES-1:0][7:0]  flit to PHY.
- o_rx_valid  output  1  received flit valid.
- o_rx_data  output  [NBYTES-1:0][7:0]  received flit.
- o_fifo_full  output  1  FIFO full.
- o_fifo_empty  output  1  FIFO empty.
- o_tx_count  output  16  flits accepted by the PHY.
- o_rx_count  output  16  flits received from the PHY.
- o_stall_err  output  1  sticky stall-timeout flag.
- o_mismatch  output  1  loopback mismatch pulse (optional feature).
- o_mismatch_count  output  16  mismatch count (optional feature).

Behaviour:
- Reset (async, i_rst_n=0):
  - State is RESET; FIFO pointers are 0.
  - All outputs are 0, except o_fifo_empty=1.
- States: RESET, IDLE, SEND.
  - RESET -> IDLE when i_enable=1.
  - IDLE -> SEND when the FIFO is non-empty.
  - SEND -> IDLE when the last entry pops and no push happens that cycle.
  - From any state, i_enable=0 -> RESET on the next edge.
- In RESET:
  - FIFO is flushed synchronously and counters are cleared.
  - o_stall_err clears.
  - o_tx_ready=0; lp outputs are 0.
- Push:
  - o_tx_ready = (state!=RESET) && !o_fifo_full.
  - A push occurs when i_tx_valid && o_tx_ready.
  - A pop in the same cycle does not raise o_tx_ready when full.
- Transmit:
  - o_rdi_lp_valid = o_rdi_lp_irdy = (state==SEND).
  - o_rdi_lp_data = FIFO head when in SEND, else 0.
  - Transfer = lp_valid && i_rdi_pl_trdy. It pops the head and increments o_tx_count, wrapping at 0xFFFF->0.
  - Latency: a flit pushed into an empty FIFO appears on lp_data 1 cycle later.
  - Data is held stable while pl_trdy=0.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance (pointer wrap at DEPTH).
- Receive:
  - When state!=RESET and i_rdi_pl_valid=1, o_rx_data <= i_rdi_pl_data, o_rx_valid <= 1, and o_rx_count increments (wraps). Otherwise o_rx_valid <= 0.
  - o_rx_data holds its last value when o_rx_valid=0.
  - Latency is 1 cycle.
- Stall watchdog:
  - The counter increments each SEND cycle with pl_trdy=0 and clears on any transfer or when leaving SEND.
  - On reaching STALL_LIMIT, o_stall_err sets and stays set until RESET.
  - Transmission continues while the flag is set.
- Reset mid-operation:
  - Async reset or i_enable drop discards FIFO contents.
  - No partial flit is ever presented.

Optional Feature:
- Macro: UCIE_CTL_ADAPTER_LOOPBACK_CHK_EN.
- Enabled:
  - Each transferred flit is also pushed into a DEPTH-entry expected-data FIFO.
  - On each registered rx flit, the oldest expected flit is popped and compared.
  - On inequality, o_mismatch pulses for 1 cycle concurrent with o_rx_valid, and o_mismatch_count increments, saturating at 0xFFFF.
  - An rx flit arriving with the expected FIFO empty counts as a mismatch.
  - A push into a full expected FIFO is dropped.
  - The expected FIFO is cleared in RESET.
- Disabled: o_mismatch=0 and o_mismatch_count=0; no expected-data storage is built.

Test Plan:
- Bring-up: release reset, i_enable=1, push one flit of bytes 0x00..0x1F, pl_trdy=1 -> lp_valid high exactly 1 cycle carrying 0x00..0x1F; o_tx_count=1; return to IDLE.
- Backpressure: push 4 flits with pl_trdy=0 -> o_fifo_full=1 and o_tx_ready=0 after the 4th. Then pl_trdy=1 -> 4 flits leave in order over 4 consecutive cycles; o_tx_count=4.
- Stall timeout: with STALL_LIMIT=16, hold pl_trdy=0 with 1 flit queued for 16 cycles -> o_stall_err=1. Flag stays set after the transfer and clears only on i_enable=0.
- Receive: pl_valid=1 for 3 cycles with data 0xA5 repeated, then 0x5A repeated, then 0x3C repeated -> o_rx_valid high 3 cycles, 1 cycle delayed, same data order; o_rx_count=3.
- Enable drop: with 3 flits queued, drop i_enable -> lp_valid=0 next cycle, o_fifo_empty=1, counters 0. Re-enable and send 1 flit -> only the new flit is transmitted.
- Loopback (macro on): send 2 flits, return the first unchanged and the second with byte0 XOR 0xF2 -> o_mismatch pulses once, on the 2nd rx; o_mismatch_count=1.

Source files
------------

// File: rtl/ucie_ctl_adapter_data_transfer.sv
// Adapter-side RDI data path: TX flit FIFO toward the PHY, registered RX capture, flit counters and stall watchdog.
// Optional loopback checker enabled by defining UCIE_CTL_ADAPTER_LOOPBACK_CHK_EN.
module ucie_ctl_adapter_data_transfer #(
    parameter int NBYTES      = 32,
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_tx_valid,
    input  logic [NBYTES-1:0][7:0] i_tx_data,
    output logic                   o_tx_ready,
    input  logic                   i_rdi_pl_trdy,
    input  logic                   i_rdi_pl_valid,
    input  logic [NBYTES-1:0][7:0] i_rdi_pl_data,
    output logic                   o_rdi_lp_irdy,
    output logic                   o_rdi_lp_valid,
    output logic [NBYTES-1:0][7:0] o_rdi_lp_data,
    output logic                   o_rx_valid,
    output logic [NBYTES-1:0][7:0] o_rx_data,
    output logic                   o_fifo_full,
    output logic                   o_fifo_empty,
    output logic [15:0]            o_tx_count,
    output logic [15:0]            o_rx_count,
    output logic                   o_stall_err,
    output logic                   o_mismatch,
    output logic [15:0]            o_mismatch_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);

    typedef logic [NBYTES-1:0][7:0] flit_t;
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    flit_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic [SW-1:0] r_stall_cnt;
    logic          r_stall_err;
    logic [15:0]   r_tx_count, r_rx_count;
    logic          r_rx_valid;
    flit_t         r_rx_data;
    logic          w_flush, w_push, w_pop, w_send, w_full, w_empty, w_rx_take;

    // Dropping i_enable discards queued flits on the same edge that leaves the link.
    assign w_flush   = (r_state == ST_RESET) || !i_enable;
    assign w_send    = (r_state == ST_SEND);
    assign w_full    = (r_count == L_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push    = i_tx_valid && o_tx_ready;
    assign w_pop     = w_send && i_rdi_pl_trdy;
    assign w_rx_take = (r_state != ST_RESET) && i_rdi_pl_valid;

    assign o_tx_ready     = (r_state != ST_RESET) && !w_full;
    assign o_rdi_lp_valid = w_send;
    assign o_rdi_lp_irdy  = w_send;
    assign o_rdi_lp_data  = w_send ? r_mem[r_rd_ptr] : '0;
    assign o_fifo_full    = w_full;
    assign o_fifo_empty   = w_empty;
    assign o_tx_count     = r_tx_count;
    assign o_rx_count     = r_rx_count;
    assign o_rx_valid     = r_rx_valid;
    assign o_rx_data      = r_rx_data;
    assign o_stall_err    = r_stall_err;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
            2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next-state looks at the post-edge occupancy so a push into an empty FIFO shows up one cycle later.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RESET: if (i_enable) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (w_count_nxt != '0) w_state_nxt = ST_SEND;
            ST_SEND:  if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_RESET;
        endcase
        if (!i_enable) w_state_nxt = ST_RESET;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_RESET;
        else          r_state <= w_state_nxt;
    end

    // NOTE: flit storage has no reset; r_count alone decides which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_tx_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_count <= '0;
            r_rx_count <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= w_rx_take;
            if (w_rx_take) r_rx_data <= i_rdi_pl_data;
            if (w_flush) begin
                r_tx_count <= '0;
                r_rx_count <= '0;
            end else begin
                if (w_pop)     r_tx_count <= r_tx_count + 16'd1;
                if (w_rx_take) r_rx_count <= r_rx_count + 16'd1;
            end
        end
    end

    // Watchdog counts consecutive SEND cycles without pl_trdy; the error flag is sticky until the link resets.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else if (w_flush) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else if (w_send && !i_rdi_pl_trdy) begin
            if (r_stall_cnt < SW'(STALL_LIMIT))      r_stall_cnt <= r_stall_cnt + SW'(1);
            if (r_stall_cnt >= SW'(STALL_LIMIT - 1)) r_stall_err <= 1'b1;
        end else begin
            r_stall_cnt <= '0;
        end
    end

`ifdef UCIE_CTL_ADAPTER_LOOPBACK_CHK_EN
    flit_t         r_exp_mem [DEPTH];
    logic [AW-1:0] r_exp_wr_ptr, r_exp_rd_ptr;
    logic [AW:0]   r_exp_count;
    logic          r_mismatch;
    logic [15:0]   r_mismatch_count;
    logic          w_exp_push, w_exp_pop, w_exp_empty, w_mismatch_now;

    assign w_exp_empty    = (r_exp_count == '0);
    assign w_exp_push     = w_pop && (r_exp_count != L_DEPTH);
    assign w_exp_pop      = w_rx_take && !w_exp_empty;
    assign w_mismatch_now = w_rx_take && (w_exp_empty || (r_exp_mem[r_exp_rd_ptr] != i_rdi_pl_data));

    always_ff @(posedge i_clk) begin
        if (w_exp_push) r_exp_mem[r_exp_wr_ptr] <= o_rdi_lp_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp_wr_ptr     <= '0;
            r_exp_rd_ptr     <= '0;
            r_exp_count      <= '0;
            r_mismatch       <= 1'b0;
            r_mismatch_count <= '0;
        end else begin
            r_mismatch <= w_mismatch_now;
            if (w_flush) begin
                r_exp_wr_ptr     <= '0;
                r_exp_rd_ptr     <= '0;
                r_exp_count      <= '0;
                r_mismatch_count <= '0;
            end else begin
                if (w_exp_push) r_exp_wr_ptr <= r_exp_wr_ptr + AW'(1);
                if (w_exp_pop)  r_exp_rd_ptr <= r_exp_rd_ptr + AW'(1);
                r_exp_count <= r_exp_count + (AW + 1)'(w_exp_push) - (AW + 1)'(w_exp_pop);
                if (w_mismatch_now && (r_mismatch_count != 16'hFFFF))
                    r_mismatch_count <= r_mismatch_count + 16'd1;
            end
        end
    end

    assign o_mismatch       = r_mismatch;
    assign o_mismatch_count = r_mismatch_count;
`else
    assign o_mismatch       = 1'b0;
    assign o_mismatch_count = '0;
`endif

endmodule

// File: tb/tb_ucie_ctl_adapter_data_transfer.sv
// Randomized and directed bench for ucie_ctl_adapter_data_transfer against a queue-based reference model.
module tb_ucie_ctl_adapter_data_transfer;

    localparam int NBYTES      = 32;
    localparam int DEPTH       = 4;
    localparam int STALL_LIMIT = 16;

    typedef logic [NBYTES-1:0][7:0] flit_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_tx_valid = 1'b0;
    flit_t       i_tx_data = '0;
    logic        i_rdi_pl_trdy = 1'b0;
    logic        i_rdi_pl_valid = 1'b0;
    flit_t       i_rdi_pl_data = '0;
    logic        o_tx_ready, o_rdi_lp_irdy, o_rdi_lp_valid, o_rx_valid;
    flit_t       o_rdi_lp_data, o_rx_data;
    logic        o_fifo_full, o_fifo_empty, o_stall_err, o_mismatch;
    logic [15:0] o_tx_count, o_rx_count, o_mismatch_count;

    ucie_ctl_adapter_data_transfer #(
        .NBYTES(NBYTES), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data), .o_tx_ready(o_tx_ready),
        .i_rdi_pl_trdy(i_rdi_pl_trdy), .i_rdi_pl_valid(i_rdi_pl_valid), .i_rdi_pl_data(i_rdi_pl_data),
        .o_rdi_lp_irdy(o_rdi_lp_irdy), .o_rdi_lp_valid(o_rdi_lp_valid), .o_rdi_lp_data(o_rdi_lp_data),
        .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data),
        .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty),
        .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_stall_err(o_stall_err),
        .o_mismatch(o_mismatch), .o_mismatch_count(o_mismatch_count)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: the link is "up" from the edge after enable is seen until enable drops;
    // the TX FIFO is a queue, the PHY sees its head whenever the link is up and the queue is non-empty.
    flit_t       mq[$];
    flit_t       em[$];
    bit          m_up, m_err, m_rxv, m_mm;
    int          m_stall;
    logic [15:0] m_txc, m_rxc, m_mmc;
    flit_t       m_rxd;

    task automatic model_reset();
        mq.delete();
        em.delete();
        m_up = 0; m_err = 0; m_rxv = 0; m_mm = 0; m_stall = 0;
        m_txc = '0; m_rxc = '0; m_mmc = '0; m_rxd = '0;
    endtask

    task automatic model_step();
        bit    send, pop, push, take, mm_now, exp_room;
        flit_t head;
        send     = m_up && (mq.size() != 0);
        pop      = send && i_rdi_pl_trdy;
        push     = i_tx_valid && m_up && (mq.size() < DEPTH);
        take     = m_up && i_rdi_pl_valid;
        head     = send ? mq[0] : '0;
        mm_now   = take && ((em.size() == 0) || (em[0] != i_rdi_pl_data));
        exp_room = em.size() < DEPTH;
        m_rxv = take;
        if (take) m_rxd = i_rdi_pl_data;
        m_mm = mm_now;
        if (!i_enable) begin
            mq.delete();
            em.delete();
            m_up = 0; m_txc = '0; m_rxc = '0; m_mmc = '0; m_stall = 0; m_err = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_txc = m_txc + 16'd1;
            end
            if (push) mq.push_back(i_tx_data);
            if (send && !i_rdi_pl_trdy) begin
                m_stall++;
                if (m_stall >= STALL_LIMIT) m_err = 1;
            end else begin
                m_stall = 0;
            end
            if (take) m_rxc = m_rxc + 16'd1;
            if (take && em.size() != 0) void'(em.pop_front());
            if (pop && exp_room) em.push_back(head);
            if (mm_now && m_mmc != 16'hFFFF) m_mmc = m_mmc + 16'd1;
            m_up = 1;
        end
    endtask

    task automatic check_all();
        bit    send;
        flit_t head;
        send = m_up && (mq.size() != 0);
        head = send ? mq[0] : '0;
        check("lp_valid", o_rdi_lp_valid, send);
        check("lp_irdy", o_rdi_lp_irdy, send);
        check("lp_data", o_rdi_lp_data, head);
        check("tx_ready", o_tx_ready, m_up && (mq.size() < DEPTH));
        check("fifo_full", o_fifo_full, mq.size() == DEPTH);
        check("fifo_empty", o_fifo_empty, mq.size() == 0);
        check("tx_count", o_tx_count, m_txc);
        check("rx_count", o_rx_count, m_rxc);
        check("rx_valid", o_rx_valid, m_rxv);
        check("rx_data", o_rx_data, m_rxd);
        check("stall_err", o_stall_err, m_err);
`ifdef UCIE_CTL_ADAPTER_LOOPBACK_CHK_EN
        check("mismatch", o_mismatch, m_mm);
        check("mm_count", o_mismatch_count, m_mmc);
`else
        check("mismatch", o_mismatch, 1'b0);
        check("mm_count", o_mismatch_count, 16'd0);
`endif
    endtask

    // Called at a negedge: compare, advance the model with the current inputs, cross one posedge.
    task automatic cycle();
        check_all();
        model_step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drive(input bit en, input bit tv, input flit_t td, input bit trdy,
                         input bit pv, input flit_t pd);
        i_enable       = en;
        i_tx_valid     = tv;
        i_tx_data      = td;
        i_rdi_pl_trdy  = trdy;
        i_rdi_pl_valid = pv;
        i_rdi_pl_data  = pd;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic relink();
        drive(0, 0, '0, 0, 0, '0);
        cycle();
        drive(1, 0, '0, 0, 0, '0);
        cycle();
    endtask

    function automatic flit_t rand_flit();
        flit_t f;
        for (int b = 0; b < NBYTES; b++) f[b] = 8'($urandom);
        return f;
    endfunction

    function automatic flit_t fill_flit(input logic [7:0] v);
        flit_t f;
        for (int b = 0; b < NBYTES; b++) f[b] = v;
        return f;
    endfunction

    initial begin
        flit_t inc, a, b, saved [4];
        @(negedge i_clk);
        do_reset();
        check("rst_empty", o_fifo_empty, 1'b1);
        check("rst_ready", o_tx_ready, 1'b0);

        // Bring-up: one flit 0x00..0x1F with pl_trdy=1
        for (int i = 0; i < NBYTES; i++) inc[i] = 8'(i);
        drive(1, 0, '0, 1, 0, '0);
        cycle();
        drive(1, 1, inc, 1, 0, '0);
        cycle();
        check("bringup_valid", o_rdi_lp_valid, 1'b1);
        check("bringup_data", o_rdi_lp_data, inc);
        drive(1, 0, '0, 1, 0, '0);
        cycle();
        check("bringup_done", o_rdi_lp_valid, 1'b0);
        check("bringup_txc", o_tx_count, 16'd1);

        // Backpressure: fill with pl_trdy=0, then drain in order
        relink();
        for (int i = 0; i < 4; i++) begin
            saved[i] = rand_flit();
            drive(1, 1, saved[i], 0, 0, '0);
            cycle();
        end
        check("bp_full", o_fifo_full, 1'b1);
        check("bp_ready", o_tx_ready, 1'b0);
        drive(1, 0, '0, 1, 0, '0);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", o_rdi_lp_valid, 1'b1);
            check("bp_order", o_rdi_lp_data, saved[i]);
            cycle();
        end
        check("bp_txc", o_tx_count, 16'd4);
        check("bp_empty", o_fifo_empty, 1'b1);

        // Stall timeout
        relink();
        drive(1, 1, rand_flit(), 0, 0, '0);
        cycle();
        drive(1, 0, '0, 0, 0, '0);
        for (int i = 0; i < STALL_LIMIT - 1; i++) cycle();
        check("stall_pre", o_stall_err, 1'b0);
        cycle();
        check("stall_set", o_stall_err, 1'b1);
        drive(1, 0, '0, 1, 0, '0);
        cycle();
        check("stall_sticky", o_stall_err, 1'b1);
        check("stall_txc", o_tx_count, 16'd1);
        drive(0, 0, '0, 0, 0, '0);
        cycle();
        check("stall_clear", o_stall_err, 1'b0);

        // Receive
        relink();
        drive(1, 0, '0, 0, 1, fill_flit(8'hA5));
        cycle();
        check("rx0_v", o_rx_valid, 1'b1);
        check("rx0_d", o_rx_data, fill_flit(8'hA5));
        drive(1, 0, '0, 0, 1, fill_flit(8'h5A));
        cycle();
        check("rx1_d", o_rx_data, fill_flit(8'h5A));
        drive(1, 0, '0, 0, 1, fill_flit(8'h3C));
        cycle();
        check("rx2_d", o_rx_data, fill_flit(8'h3C));
        drive(1, 0, '0, 0, 0, '0);
        cycle();
        check("rx_end_v", o_rx_valid, 1'b0);
        check("rx_hold", o_rx_data, fill_flit(8'h3C));
        check("rx_cnt", o_rx_count, 16'd3);

        // Enable drop with queued flits
        relink();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, rand_flit(), 0, 0, '0);
            cycle();
        end
        drive(0, 0, '0, 0, 0, '0);
        cycle();
        check("drop_lpv", o_rdi_lp_valid, 1'b0);
        check("drop_empty", o_fifo_empty, 1'b1);
        check("drop_txc", o_tx_count, 16'd0);
        drive(1, 0, '0, 1, 0, '0);
        cycle();
        a = rand_flit();
        drive(1, 1, a, 1, 0, '0);
        cycle();
        check("drop_new", o_rdi_lp_data, a);
        drive(1, 0, '0, 1, 0, '0);
        cycle();
        check("drop_txc1", o_tx_count, 16'd1);
        check("drop_empty1", o_fifo_empty, 1'b1);

`ifdef UCIE_CTL_ADAPTER_LOOPBACK_CHK_EN
        // Loopback: second returned flit has byte0 corrupted
        relink();
        a = rand_flit();
        b = rand_flit();
        drive(1, 1, a, 1, 0, '0);
        cycle();
        drive(1, 1, b, 1, 0, '0);
        cycle();
        drive(1, 0, '0, 1, 0, '0);
        cycle();
        drive(1, 0, '0, 0, 1, a);
        cycle();
        check("lb_first", o_mismatch, 1'b0);
        b[0] = b[0] ^ 8'hF2;
        drive(1, 0, '0, 0, 1, b);
        cycle();
        check("lb_second", o_mismatch, 1'b1);
        check("lb_count", o_mismatch_count, 16'd1);
        drive(1, 0, '0, 0, 0, '0);
        cycle();
        check("lb_pulse", o_mismatch, 1'b0);
`endif

        // Async reset mid-operation
        relink();
        drive(1, 1, rand_flit(), 0, 1, rand_flit());
        cycle();
        cycle();
        do_reset();
        check("areset_lpv", o_rdi_lp_valid, 1'b0);

        // Randomized traffic in phases of differing PHY readiness
        for (int p = 0; p < 3; p++) begin
            int trdy_pct;
            trdy_pct = (p == 0) ? 60 : (p == 1) ? 4 : 90;
            for (int c = 0; c < 1200; c++) begin
                bit en;
                en = ($urandom_range(99) >= 1);
                drive(en, $urandom_range(1), rand_flit(), ($urandom_range(99) < trdy_pct),
                      en && ($urandom_range(99) < 30), rand_flit());
                cycle();
            end
        end
        drive(0, 0, '0, 0, 0, '0);
        cycle();
        check_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
